// File: rtl/ahb_sram_slave_wait_if.sv
// AHB slave-side bus bundle and response encoding shared by the SRAM slave and its bus master.
package ahb_sram_slave_wait_pkg;
    typedef logic [1:0] hresp_t;
    localparam hresp_t HRESP_OKAY  = 2'b00;
    localparam hresp_t HRESP_ERROR = 2'b01;
endpackage

interface ahb_sram_slave_wait_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int NO_OF_MASTERS = 4
);
    import ahb_sram_slave_wait_pkg::*;

    logic                     HSEL;
    logic [ADDR_WIDTH-1:0]    HADDR;
    logic [1:0]               HTRANS;
    logic                     HWRITE;
    logic [2:0]               HSIZE;
    logic [DATA_WIDTH-1:0]    HWDATA;
    logic                     HREADY;
    logic [DATA_WIDTH-1:0]    HRDATA;
    logic                     HREADYOUT;
    hresp_t                   HRESP;
    logic [NO_OF_MASTERS-1:0] HSPLIT;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP, HSPLIT
    );
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP, HSPLIT
    );
endinterface

// File: rtl/ahb_sram_slave_wait.sv
// Parametrised AHB SRAM slave with wait states, byte-lane writes, two-cycle ERROR
// responses and read-after-write forwarding across the address/data pipeline.
module ahb_sram_slave_wait
    import ahb_sram_slave_wait_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_BYTES     = 8192,
    parameter int WAIT_STATES   = 0,
    parameter int NO_OF_MASTERS = 4
) (
    input  logic HCLK,
    input  logic HRESET,
    ahb_sram_slave_wait_if.slave s_bus
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BW_LOG = $clog2(BYTES);
    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int WORDS  = MEM_BYTES / BYTES;
    localparam int IDX_W  = MEM_AW - BW_LOG;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_dp_valid;
    logic                  r_dp_write;
    logic [IDX_W-1:0]      r_dp_idx;
    logic [BYTES-1:0]      r_dp_be;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_acc_idx;
    logic [BYTES-1:0]      w_be_base;
    logic [BYTES-1:0]      w_be;
    logic [DATA_WIDTH-1:0] w_fwd_word;

    assign w_ready   = (r_state == S_IDLE) || (r_state == S_ERR2) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_accept  = s_bus.HSEL && s_bus.HREADY && w_ready &&
                       ((s_bus.HTRANS == 2'b10) || (s_bus.HTRANS == 2'b11));
    assign w_illegal = (s_bus.HADDR[ADDR_WIDTH-1:MEM_AW] != '0) ||
                       (s_bus.HSIZE > 3'(BW_LOG)) ||
                       ((s_bus.HADDR[6:0] & ((7'd1 << s_bus.HSIZE) - 7'd1)) != 7'd0);
    assign w_acc_idx = s_bus.HADDR[MEM_AW-1:BW_LOG];
    assign w_commit  = r_dp_valid && r_dp_write && w_ready;

    always_comb begin
        w_be_base = '0;
        for (int b = 0; b < BYTES; b++)
            if (b < (1 << s_bus.HSIZE)) w_be_base[b] = 1'b1;
    end
    assign w_be = w_be_base << s_bus.HADDR[BW_LOG-1:0];

    // A write completing on the same edge a read of that word is accepted is merged in here.
    always_comb begin
        w_fwd_word = r_mem[w_acc_idx];
        for (int b = 0; b < BYTES; b++)
            if (w_commit && (r_dp_idx == w_acc_idx) && r_dp_be[b])
                w_fwd_word[8*b +: 8] = s_bus.HWDATA[8*b +: 8];
    end

    always_ff @(posedge HCLK) begin
        if (w_commit)
            for (int b = 0; b < BYTES; b++)
                if (r_dp_be[b]) r_mem[r_dp_idx][8*b +: 8] <= s_bus.HWDATA[8*b +: 8];
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_idx   <= '0;
            r_dp_be    <= '0;
            r_rdata    <= '0;
        end else if (w_ready) begin
            r_dp_valid <= w_accept && !w_illegal;
            r_dp_write <= w_accept && s_bus.HWRITE;
            r_dp_idx   <= w_acc_idx;
            r_dp_be    <= w_be;
            if (w_accept)
                r_rdata <= (!w_illegal && !s_bus.HWRITE) ? w_fwd_word : '0;
            if (!w_accept) begin
                r_state <= S_IDLE;
            end else if (w_illegal) begin
                r_state <= S_ERR1;
            end else if (WS != 4'd0) begin
                r_state <= S_WAIT;
                r_cnt   <= WS;
            end else begin
                r_state <= S_IDLE;
            end
        end else if (r_state == S_ERR1) begin
            r_state <= S_ERR2;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign s_bus.HRDATA    = r_rdata;
    assign s_bus.HREADYOUT = w_ready;
    assign s_bus.HRESP     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign s_bus.HSPLIT    = '0;
endmodule

// File: doc/ahb_sram_slave_wait.md
Name: ahb_sram_slave_wait

Overview:
- Parametrised AHB-Lite SRAM slave, the successor to the fixed 8 KB zero-wait SRAM slave.
- Configurable data width, memory depth and wait states.
- Correct address/data phase pipelining: write data is taken in the data phase, with read-after-write forwarding.
- Byte-lane writes for any legal HSIZE; two-cycle ERROR response for illegal or out-of-range accesses.
- Sits behind the AHB decoder/mux in the same slot as the existing SRAM slave. SPLIT/RETRY are not supported.

Parameters:
- DATA_WIDTH, 32, bus data width in bits: 32 or 64.
- ADDR_WIDTH, 32, HADDR width.
- MEM_BYTES, 8192, SRAM size in bytes; power of two, multiple of DATA_WIDTH/8.
- WAIT_STATES, 0, wait cycles (0..15) inserted in each valid data phase.
- NO_OF_MASTERS, 4, width of HSPLIT.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (mux output).
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  hresp_t  OKAY/ERROR only.
- HSPLIT  out  NO_OF_MASTERS  tied 0.

Behaviour:

Reset (HRESET=1, async):
- HRDATA=0, HREADYOUT=1, HRESP=OKAY, HSPLIT=0.
- FSM to IDLE, wait counter 0, captured address-phase registers cleared.
- Memory contents are not reset.
- Reset mid-transfer aborts it; a pending write is not committed.

Address phase accept:
- A transfer is accepted on a rising HCLK when HSEL & HREADY & HTRANS is NONSEQ or SEQ.
- Captured: HADDR, HWRITE, HSIZE.
- Offset = HADDR mod 2^ADDR_WIDTH relative to the slave base; the low log2(MEM_BYTES) bits index memory.
- An access is illegal if any of these holds:
  - HADDR[ADDR_WIDTH-1:log2(MEM_BYTES)] != 0;
  - 8<<HSIZE > DATA_WIDTH;
  - HADDR is not aligned to 1<<HSIZE.
- IDLE/BUSY, or HSEL=0 with HREADY=1: nothing captured; the next data phase is a zero-wait OKAY.

FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE → WAIT: legal accept and WAIT_STATES>0. HREADYOUT=0 for exactly WAIT_STATES cycles, then HREADYOUT=1, OKAY.
- IDLE stays IDLE: legal accept and WAIT_STATES=0. The data phase completes in the next cycle with HREADYOUT=1.
- Illegal accept → ERR1. ERR1 drives HREADYOUT=0, HRESP=ERROR, then goes to ERR2. ERR2 drives HREADYOUT=1, HRESP=ERROR, then goes to IDLE.
- Illegal writes never modify memory. Illegal reads give HRDATA=0.
- A new transfer may be accepted in the final (HREADYOUT=1) cycle of any data phase, including ERR2. Back-to-back transfers are pipelined.

Byte enables:
- Computed from the captured HSIZE and address: (2^(1<<HSIZE)-1) << HADDR[log2(DATA_WIDTH/8)-1:0].

Write:
- Committed on the rising edge ending the data phase (HREADYOUT=1).
- Only enabled lanes of HWDATA are written, at word index = offset >> log2(DATA_WIDTH/8).

Read:
- Memory word is read when the transfer is accepted and registered into HRDATA.
- HRDATA is held stable until the data phase completes; it is full word width, and the master selects lanes.

Forwarding:
- A read accepted in the same cycle that a write to the same word completes returns memory merged with that write's enabled HWDATA lanes.
- Other lanes come from old memory contents.

Address wrap: highest legal word (offset MEM_BYTES-DATA_WIDTH/8) is valid; offset MEM_BYTES is ERROR.

Test Plan:
- WAIT_STATES=0, DATA_WIDTH=32: write word 0xDEADBEEF @0x10, then read @0x10 → HRDATA=0xDEADBEEF, HREADYOUT never low, HRESP=OKAY.
- Byte write 0xAA at addr 0x13 (HSIZE=0, HWDATA=0xAA000000) over 0x11223344 → read 0x10 returns 0xAA223344; halfword 0xBBBB @0x10 then gives 0xAA22BBBB.
- WAIT_STATES=2: NONSEQ read @0x0 → HREADYOUT low 2 cycles, high in the 3rd with data; back-to-back SEQ @0x4 accepted in that cycle.
- Write 0x12345678 @0x20 immediately followed by read @0x20 (pipelined) → read returns 0x12345678 via forwarding.
- Access @0x2000 (MEM_BYTES=8192), HSIZE=3 on 32-bit, and halfword @0x1 → each gets ERR1 (HREADYOUT=0, ERROR) then ERR2 (HREADYOUT=1, ERROR); memory unchanged.
- Assert HRESET during a wait state of a write → outputs at reset values immediately; target word unchanged on readback.
